// File: rtl/mips_pkg.sv
// Shared MIPS encoding definitions for the instruction loader slice.
// Contents: format encodings, instruction field widths and the loader FSM
// state type.
package mips_pkg;

   localparam int OPCODE_W = 6;
   localparam int REG_W    = 5;
   localparam int SHAMT_W  = 5;
   localparam int FUNCT_W  = 6;
   localparam int IMM_W    = 16;
   localparam int ADDR26_W = 26;

   typedef enum logic [1:0] {
      FMT_R   = 2'b00,
      FMT_I   = 2'b01,
      FMT_J   = 2'b10,
      FMT_RSV = 2'b11
   } fmt_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_FULL = 2'b10
   } state_t;

endpackage

// File: rtl/instruction_pack.sv
// Pure combinational MIPS instruction packer.
// Ports:
//   fmt        : format select (R/I/J; reserved packs as R)
//   opcode, rs, rt, rd, shamt, funct, immediate, address : instruction fields
//   word       : packed 32-bit instruction
// Fields unused by the selected format are ignored.
module instruction_pack
   import mips_pkg::*;
(
   input  logic [1:0]          fmt,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [REG_W-1:0]    rs,
   input  logic [REG_W-1:0]    rt,
   input  logic [REG_W-1:0]    rd,
   input  logic [SHAMT_W-1:0]  shamt,
   input  logic [FUNCT_W-1:0]  funct,
   input  logic [IMM_W-1:0]    immediate,
   input  logic [ADDR26_W-1:0] address,
   output logic [31:0]         word
);

   always_comb begin
      word = {opcode, rs, rt, rd, shamt, funct};
      case (fmt_t'(fmt))
         FMT_I:   word = {opcode, rs, rt, immediate};
         FMT_J:   word = {opcode, address};
         default: word = {opcode, rs, rt, rd, shamt, funct};
      endcase
   end

endmodule

// File: rtl/instruction_encode_loader.sv
// Packs MIPS field bundles into 32-bit words and writes them sequentially
// into instruction memory, one word per accepted transfer, latency 1 cycle.
// Ports:
//   clk, rst_n          : clock (rising edge), synchronous active-low reset
//   start, finish       : session open/restart and close pulses (start wins)
//   in_valid, in_ready  : field bundle handshake
//   fmt, opcode .. address : instruction fields
//   imem_we/addr/wdata  : instruction memory write port
//   count, busy, full   : session status
//   err                 : sticky reserved-format flag
// Optional macro ENCODE_CHECK_EN: when defined, fmt=11 bundles are consumed
// without a write and set err (cleared by reset or start); when undefined,
// they are written as R-format and err is tied low.
//
// state | meaning
// IDLE  | no session; count holds last session's value
// LOAD  | accepting bundles, one write per accept
// FULL  | DEPTH words written; bundles ignored until start/finish
module instruction_encode_loader
   import mips_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int DEPTH     = 256,
   parameter int BASE_ADDR = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                finish,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1:0]          fmt,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [REG_W-1:0]    rs,
   input  logic [REG_W-1:0]    rt,
   input  logic [REG_W-1:0]    rd,
   input  logic [SHAMT_W-1:0]  shamt,
   input  logic [FUNCT_W-1:0]  funct,
   input  logic [IMM_W-1:0]    immediate,
   input  logic [ADDR26_W-1:0] address,
   output logic                imem_we,
   output logic [ADDR_W-1:0]   imem_addr,
   output logic [31:0]         imem_wdata,
   output logic [ADDR_W:0]     count,
   output logic                busy,
   output logic                full,
   output logic                err
);

   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   ptr;
   logic [31:0]         packed_word;
   logic                accept;
   logic                write_ok;
   logic                rsv_fmt;

   instruction_pack u_pack (
      .fmt       (fmt),
      .opcode    (opcode),
      .rs        (rs),
      .rt        (rt),
      .rd        (rd),
      .shamt     (shamt),
      .funct     (funct),
      .immediate (immediate),
      .address   (address),
      .word      (packed_word)
   );

   assign rsv_fmt = (fmt_t'(fmt) == FMT_RSV);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = (state == ST_LOAD) && !start && !finish;
      accept    = in_valid && in_ready;
`ifdef ENCODE_CHECK_EN
      write_ok  = accept && !rsv_fmt;
`else
      write_ok  = accept;
`endif
      if (start)
         state_nxt = ST_LOAD;
      else if (finish && state != ST_IDLE)
         state_nxt = ST_IDLE;
      else if (state == ST_LOAD && write_ok && (count + 1'b1) == DEPTH_C)
         state_nxt = ST_FULL;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         ptr        <= '0;
         count      <= '0;
      end else begin
         imem_we <= write_ok;
         if (write_ok) begin
            imem_addr  <= ptr;
            imem_wdata <= packed_word;
            ptr        <= ptr + 1'b1;
            count      <= count + 1'b1;
         end
         // in_ready is low during start, so this never collides with a write
         if (start) begin
            ptr   <= BASE_C;
            count <= '0;
         end
      end
   end

`ifdef ENCODE_CHECK_EN
   always_ff @(posedge clk) begin
      if (!rst_n)                  err <= 1'b0;
      else if (start)              err <= 1'b0;
      else if (accept && rsv_fmt)  err <= 1'b1;
   end
`else
   assign err = 1'b0;
   logic unused_rsv;
   assign unused_rsv = rsv_fmt;
`endif

   assign busy = (state != ST_IDLE);
   assign full = (count == DEPTH_C);

endmodule

// File: tb/tb_instruction_encode_loader.sv
module tb_instruction_encode_loader;
   import mips_pkg::*;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 4;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                start, finish, in_valid, in_ready;
   logic [1:0]          fmt;
   logic [OPCODE_W-1:0] opcode;
   logic [REG_W-1:0]    rs, rt, rd;
   logic [SHAMT_W-1:0]  shamt;
   logic [FUNCT_W-1:0]  funct;
   logic [IMM_W-1:0]    immediate;
   logic [ADDR26_W-1:0] address;
   logic                imem_we;
   logic [ADDR_W-1:0]   imem_addr;
   logic [31:0]         imem_wdata;
   logic [ADDR_W:0]     count;
   logic                busy, full, err;

   int n_checks = 0;
   int n_errors = 0;
   int n_writes;

   instruction_encode_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt),
      .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
      .funct(funct), .immediate(immediate), .address(address),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .count(count), .busy(busy), .full(full), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_r(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn);
      fmt = 2'b00; opcode = op; rs = s; rt = t; rd = d; shamt = sh; funct = fn;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 0; finish = 0; in_valid = 0;
      fmt = 0; opcode = 0; rs = 0; rt = 0; rd = 0; shamt = 0; funct = 0;
      immediate = 0; address = 0;
      step(); step();

      check_eq("rst_in_ready", in_ready, 0);
      check_eq("rst_we", imem_we, 0);
      check_eq("rst_addr", imem_addr, 0);
      check_eq("rst_wdata", imem_wdata, 0);
      check_eq("rst_count", count, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_full", full, 0);
      check_eq("rst_err", err, 0);

      // R-format single write
      rst_n = 1'b1;
      step();
      pulse_start();
      check_eq("start_busy", busy, 1);
      check_eq("start_count", count, 0);
      set_r(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
      in_valid = 1'b1;
      #1 check_eq("r_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      check_eq("r_we", imem_we, 1);
      check_eq("r_addr", imem_addr, 0);
      check_eq("r_wdata", imem_wdata, 32'h0022_1820);
      check_eq("r_count", count, 1);
      step();
      check_eq("r_we_drop", imem_we, 0);
      check_eq("r_wdata_hold", imem_wdata, 32'h0022_1820);

      // I then J back-to-back in a fresh session
      pulse_start();
      check_eq("restart_count", count, 0);
      fmt = 2'b01; opcode = 6'h23; rs = 5'd29; rt = 5'd8; immediate = 16'hFFFC;
      in_valid = 1'b1;
      step();
      check_eq("i_we", imem_we, 1);
      check_eq("i_addr", imem_addr, 0);
      check_eq("i_wdata", imem_wdata, 32'h8FA8_FFFC);
      fmt = 2'b10; opcode = 6'h02; address = 26'h010_0000;
      step();
      in_valid = 1'b0;
      check_eq("j_we", imem_we, 1);
      check_eq("j_addr", imem_addr, 1);
      check_eq("j_wdata", imem_wdata, 32'h0810_0000);
      check_eq("j_count", count, 2);

      // fill to DEPTH with in_valid held high for 6 bundles
      pulse_start();
      n_writes = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         set_r(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'(i));
         step();
         if (imem_we) n_writes++;
         check_eq($sformatf("fill_we_%0d", i), imem_we, (i < DEPTH) ? 1 : 0);
         if (i < DEPTH) begin
            check_eq($sformatf("fill_addr_%0d", i), imem_addr, i);
            check_eq($sformatf("fill_wdata_%0d", i), imem_wdata, 32'h0022_1800 | i);
         end
      end
      check_eq("fill_nwrites", n_writes, DEPTH);
      check_eq("fill_full", full, 1);
      check_eq("fill_in_ready", in_ready, 0);
      check_eq("fill_count", count, DEPTH);
      check_eq("fill_busy", busy, 1);

      // bundle during start and during finish is not accepted
      start = 1'b1;
      #1 check_eq("start_cycle_ready", in_ready, 0);
      step();
      start = 1'b0;
      check_eq("start_cycle_we", imem_we, 0);
      check_eq("start_cycle_count", count, 0);
      check_eq("start_cycle_full", full, 0);
      step();
      check_eq("one_we", imem_we, 1);
      check_eq("one_count", count, 1);
      finish = 1'b1;
      #1 check_eq("finish_cycle_ready", in_ready, 0);
      step();
      finish = 1'b0;
      check_eq("finish_cycle_we", imem_we, 0);
      check_eq("finish_busy", busy, 0);
      check_eq("finish_count", count, 1);
      step();
      in_valid = 1'b0;
      check_eq("idle_count_hold", count, 1);
      check_eq("idle_we", imem_we, 0);

      // reset in the cycle after an accept discards everything
      pulse_start();
      set_r(6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F);
      in_valid = 1'b1;
      step();
      check_eq("pre_rst_we", imem_we, 1);
      rst_n = 1'b0;
      step();
      in_valid = 1'b0;
      check_eq("mid_rst_we", imem_we, 0);
      check_eq("mid_rst_addr", imem_addr, 0);
      check_eq("mid_rst_wdata", imem_wdata, 0);
      check_eq("mid_rst_count", count, 0);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_full", full, 0);
      check_eq("mid_rst_err", err, 0);
      rst_n = 1'b1;
      in_valid = 1'b1;
      #1 check_eq("mid_rst_idle_ready", in_ready, 0);
      step();
      in_valid = 1'b0;
      check_eq("idle_no_write", imem_we, 0);

      // reserved format
      pulse_start();
      set_r(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
      fmt = 2'b11;
      in_valid = 1'b1;
      #1 check_eq("rsv_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
`ifdef ENCODE_CHECK_EN
      check_eq("rsv_we", imem_we, 0);
      check_eq("rsv_err", err, 1);
      check_eq("rsv_count", count, 0);
      step();
      check_eq("rsv_err_sticky", err, 1);
`else
      check_eq("rsv_we", imem_we, 1);
      check_eq("rsv_wdata", imem_wdata, 32'h0022_1820);
      check_eq("rsv_count", count, 1);
      check_eq("rsv_err", err, 0);
`endif
      pulse_start();
      check_eq("start_clears_err", err, 0);
      check_eq("start_clears_count", count, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
